ghr_hash_index: RTL and testbench

//  Next-generation predictor index generator. It XOR-folds the fetch PC and a

---
 rtl/ghr_hash_index.sv | 112 +++++++++++
 tb/tb_ghr_hash_index.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ghr_hash_index.sv
// Predictor index generator: XOR-folds fetch PC with a speculative global history
// register, and keeps per-branch GHR checkpoints for mispredict recovery.
module ghr_hash_index #(
    parameter int PC_WIDTH   = 30,
    parameter int HASH_WIDTH = 14,
    parameter int HIST_LEN   = 16,
    parameter int CKPT_DEPTH = 8,
    localparam int TAG_W     = $clog2(CKPT_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  idx_req,
    input  logic [PC_WIDTH-1:0]   idx_pc,
    output logic [HASH_WIDTH-1:0] idx_out,
    output logic                  idx_valid,
    input  logic                  spec_valid,
    input  logic                  spec_taken,
    output logic                  spec_ready,
    output logic [TAG_W-1:0]      spec_tag,
    input  logic                  cmt_valid,
    input  logic                  rcv_valid,
    input  logic [TAG_W-1:0]      rcv_tag,
    input  logic                  rcv_taken,
    output logic [HIST_LEN-1:0]   ghr
);

    localparam int PC_CH = (PC_WIDTH + HASH_WIDTH - 1) / HASH_WIDTH;
    localparam int GH_CH = (HIST_LEN + HASH_WIDTH - 1) / HASH_WIDTH;
    localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};
    localparam logic [TAG_W:0] DEPTH_P = {1'b1, {TAG_W{1'b0}}};

    function automatic logic [HASH_WIDTH-1:0] fold_pc(input logic [PC_WIDTH-1:0] x);
        logic [PC_CH*HASH_WIDTH-1:0] ext;
        logic [HASH_WIDTH-1:0]       r;
        ext = '0;
        ext[PC_WIDTH-1:0] = x;
        r = '0;
        for (int i = 0; i < PC_CH; i++) r ^= ext[i*HASH_WIDTH +: HASH_WIDTH];
        return r;
    endfunction

    function automatic logic [HASH_WIDTH-1:0] fold_gh(input logic [HIST_LEN-1:0] x);
        logic [GH_CH*HASH_WIDTH-1:0] ext;
        logic [HASH_WIDTH-1:0]       r;
        ext = '0;
        ext[HIST_LEN-1:0] = x;
        r = '0;
        for (int i = 0; i < GH_CH; i++) r ^= ext[i*HASH_WIDTH +: HASH_WIDTH];
        return r;
    endfunction

    logic [HIST_LEN-1:0]   ghr_q, ghr_d;
    logic [TAG_W:0]        head_q, head_d, tail_q, tail_d;
    logic [HASH_WIDTH-1:0] idx_q, idx_d;
    logic                  idx_vld_q;
    logic [HIST_LEN-1:0]   ckpt_q [CKPT_DEPTH];

    logic [TAG_W:0]   count;
    logic             full, push, pop;
    logic [TAG_W-1:0] rcv_off;

    assign count      = tail_q - head_q;
    assign full       = (count == DEPTH_P);
    assign spec_ready = !full && !rcv_valid;
    assign push       = spec_valid && spec_ready;
    assign pop        = cmt_valid && (count != '0);
    // Distance of the recovered branch from the oldest in-flight entry.
    assign rcv_off    = rcv_tag - head_q[TAG_W-1:0];

    always_comb begin
        ghr_d  = ghr_q;
        tail_d = tail_q;
        head_d = head_q;
        idx_d  = idx_q;
        if (idx_req) idx_d = fold_pc(idx_pc) ^ fold_gh(ghr_q);
        if (rcv_valid) begin
            ghr_d  = {ckpt_q[rcv_tag][HIST_LEN-2:0], rcv_taken};
            tail_d = head_q + {1'b0, rcv_off} + PTR_ONE;
        end else if (push) begin
            ghr_d  = {ghr_q[HIST_LEN-2:0], spec_taken};
            tail_d = tail_q + PTR_ONE;
        end
        if (pop) head_d = head_q + PTR_ONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            idx_q     <= '0;
            idx_vld_q <= 1'b0;
        end else begin
            ghr_q     <= ghr_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            idx_q     <= idx_d;
            idx_vld_q <= idx_req;
        end
    end

    // Checkpoint storage needs no reset: entries are only read while in flight.
    always_ff @(posedge clk) begin
        if (push) ckpt_q[tail_q[TAG_W-1:0]] <= ghr_q;
    end

    assign spec_tag  = tail_q[TAG_W-1:0];
    assign ghr       = ghr_q;
    assign idx_out   = idx_q;
    assign idx_valid = idx_vld_q;

endmodule

// File: tb/tb_ghr_hash_index.sv
// Randomized bench for ghr_hash_index against a queue-based model of the
// in-flight branch window, plus hand-computed directed expectations.
module tb_ghr_hash_index;
    localparam int PCW = 30, HW = 14, HL = 16, D = 8, TW = 3;

    logic            clk = 1'b0, rst = 1'b0;
    logic            idx_req = 0, spec_valid = 0, spec_taken = 0;
    logic            cmt_valid = 0, rcv_valid = 0, rcv_taken = 0;
    logic [PCW-1:0]  idx_pc = '0;
    logic [TW-1:0]   rcv_tag = '0;
    logic [HW-1:0]   idx_out;
    logic            idx_valid, spec_ready;
    logic [TW-1:0]   spec_tag;
    logic [HL-1:0]   ghr;

    ghr_hash_index #(.PC_WIDTH(PCW), .HASH_WIDTH(HW), .HIST_LEN(HL), .CKPT_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .idx_req(idx_req), .idx_pc(idx_pc), .idx_out(idx_out),
        .idx_valid(idx_valid), .spec_valid(spec_valid), .spec_taken(spec_taken),
        .spec_ready(spec_ready), .spec_tag(spec_tag), .cmt_valid(cmt_valid),
        .rcv_valid(rcv_valid), .rcv_tag(rcv_tag), .rcv_taken(rcv_taken), .ghr(ghr));

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    // Model: oldest-first queue of pre-push GHR snapshots; base = tag of the oldest.
    int m_ghr, base, q[$];
    bit exp_iv;
    int exp_idx;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic int fold(input longint x);
        int r = 0;
        while (x != 0) begin
            r ^= int'(x % (1 << HW));
            x = x >> HW;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_ghr = 0; base = 0; q.delete(); exp_iv = 0; exp_idx = 0;
    endtask

    task automatic cycle(input bit req, input logic [PCW-1:0] pc, input bit sv, input bit st,
                         input bit cv, input bit rv, input int rtag, input bit rtk);
        int sz0, p;
        @(negedge clk);
        idx_req = req; idx_pc = pc; spec_valid = sv; spec_taken = st;
        cmt_valid = cv; rcv_valid = rv; rcv_tag = TW'(rtag); rcv_taken = rtk;
        #1;
        sz0 = q.size();
        check("spec_ready", spec_ready, (sz0 < D) && !rv);
        check("spec_tag", spec_tag, (base + sz0) % D);
        check("ghr", ghr, m_ghr);
        check("idx_valid", idx_valid, exp_iv);
        if (exp_iv) check("idx_out", idx_out, exp_idx);
        exp_iv = req;
        if (req) exp_idx = fold(pc) ^ fold(m_ghr);
        if (rv) begin
            p = (rtag - base + D) % D;
            assert (p < sz0) else $error("rcv_tag %0d outside in-flight window", rtag);
            if (p < sz0) begin
                m_ghr = ((q[p] << 1) | rtk) % (1 << HL);
                while (q.size() > p + 1) void'(q.pop_back());
            end
        end else if (sv && sz0 < D) begin
            q.push_back(m_ghr);
            m_ghr = ((m_ghr << 1) | st) % (1 << HL);
        end
        if (cv && sz0 != 0) begin
            void'(q.pop_front());
            base = (base + 1) % D;
        end
        @(posedge clk);
        #1;
        idx_req = 0; spec_valid = 0; cmt_valid = 0; rcv_valid = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    initial begin
        model_reset();
        #1 rst = 1;
        #2;
        check("rst_ghr", ghr, 0);
        check("rst_idx_valid", idx_valid, 0);
        check("rst_spec_tag", spec_tag, 0);
        check("rst_spec_ready", spec_ready, 1);
        @(negedge clk);
        rst = 0;

        // Lookup of all-ones PC with empty history
        cycle(1, 30'h3FFFFFFF, 0, 0, 0, 0, 0, 0);
        check("t1_idx_valid", idx_valid, 1);
        check("t1_idx_out", idx_out, 'h3);
        cycle(0, '0, 0, 0, 0, 0, 0, 0);
        check("t1_idx_pulse", idx_valid, 0);

        // T,T,N,T then lookup pc=0
        cycle(0, '0, 1, 1, 0, 0, 0, 0);
        cycle(0, '0, 1, 1, 0, 0, 0, 0);
        cycle(0, '0, 1, 0, 0, 0, 0, 0);
        cycle(0, '0, 1, 1, 0, 0, 0, 0);
        check("t2_ghr", ghr, 'hD);
        cycle(1, '0, 0, 0, 0, 0, 0, 0);
        check("t2_idx_out", idx_out, 'hD);

        // Recover tag 1 not-taken; next push gets tag 2
        cycle(0, '0, 0, 0, 0, 1, 1, 0);
        check("t4_ghr", ghr, 'h2);
        check("t4_tag", spec_tag, 2);

        // Recover and push together: push dropped, ghr = {ckpt[0]=0, 1}
        cycle(0, '0, 1, 0, 0, 1, 0, 1);
        check("t5_ghr", ghr, 'h1);
        check("t5_tag", spec_tag, 1);

        // Fill to full, dropped 9th push, commit re-opens
        do_reset();
        for (int i = 0; i < D; i++) cycle(0, '0, 1, 1, 0, 0, 0, 0);
        check("t3_full_ready", spec_ready, 0);
        check("t3_ghr_full", ghr, 'hFF);
        cycle(0, '0, 1, 0, 0, 0, 0, 0);
        check("t3_ghr_drop", ghr, 'hFF);
        check("t3_tag_wrap", spec_tag, 0);
        cycle(0, '0, 0, 0, 1, 0, 0, 0);
        check("t3_ready_after_cmt", spec_ready, 1);

        // Recover the head entry while committing it: window empties
        cycle(0, '0, 0, 0, 1, 1, 1, 0);
        check("rc_ghr", ghr, 'h2);
        cycle(0, '0, 0, 0, 1, 0, 0, 0);
        check("rc_empty_tag", spec_tag, 2);

        // Async reset between edges
        cycle(1, 30'h1234567, 1, 1, 0, 0, 0, 0);
        #1 rst = 1;
        #1;
        check("t6_ghr", ghr, 0);
        check("t6_idx_valid", idx_valid, 0);
        check("t6_tag", spec_tag, 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        cycle(0, '0, 1, 1, 0, 0, 0, 0);
        check("t6_ghr_after", ghr, 1);

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            bit req, sv, st, cv, rv, rtk;
            int rtag;
            req = ($urandom_range(0, 1) == 1);
            sv  = ($urandom_range(0, 9) < 6);
            st  = $urandom_range(0, 1) == 1;
            cv  = ($urandom_range(0, 9) < 3);
            rv  = (q.size() > 0) && ($urandom_range(0, 19) == 0);
            rtk = $urandom_range(0, 1) == 1;
            rtag = rv ? (base + $urandom_range(0, q.size() - 1)) % D : 0;
            cycle(req, PCW'($urandom), sv, st, cv, rv, rtag, rtk);
        end
        cycle(0, '0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
